wave_generator: RTL and testbench
=================================

WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 6: width of the accumulator, step and output level; MAX = 2^WIDTH-1.
REQ-002 SHALL have parameter PRESC_W, default 6: width of the prescaler scale input.
REQ-003 SHALL have port sysclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1: run/freeze control and output gate.
REQ-006 SHALL have port mode, input, 2: waveform select; 00 triangle, 01 sawtooth-up, 10 square, 11 sawtooth-down.
REQ-007 SHALL have port scale, input, PRESC_W: clocks per accumulator tick; value 0 treated as 1.
REQ-008 SHALL have port step, input, WIDTH: accumulator increment per tick.
REQ-009 SHALL have port duty_out, output, WIDTH: current level, intended as the duty value for a downstream PWM.
REQ-010 SHALL have port period_tick, output, 1: registered one-clock pulse marking completion of a waveform period.

Function
REQ-011 Prescaler: pre_cnt SHALL count 0..scale-1 while enable=1; tick SHALL assert in the cycle pre_cnt==scale-1, and pre_cnt SHALL wrap to 0 in that cycle.
REQ-012 Accumulator acc (WIDTH bits) and direction flag dir (0=up) SHALL update only on tick.
REQ-013 Sawtooth modes (01, 10, 11): acc SHALL take (acc+step) mod 2^WIDTH; period_tick SHALL assert on the clock after a carry out of bit WIDTH-1.
REQ-014 Triangle, dir=0: if acc+step >= MAX (WIDTH+1-bit compare), acc SHALL be set to MAX and dir to 1; otherwise acc SHALL take acc+step.
REQ-015 Triangle, dir=1: if acc <= step, acc SHALL be set to 0, dir to 0, and period_tick SHALL pulse; otherwise acc SHALL take acc-step.
REQ-016 Triangle SHALL never wrap: the saturation rules of REQ-014/015 SHALL apply at both ends.
REQ-017 duty_out SHALL be combinational from registers and SHALL be 0 when enable=0.
REQ-018 With enable=1, duty_out SHALL be: mode 00 or 01, acc; mode 10, MAX when acc[WIDTH-1]=1, else 0; mode 11, MAX-acc.
REQ-019 step=0: acc SHALL hold; no period_tick SHALL occur; the prescaler SHALL keep running.
REQ-020 enable=0: pre_cnt, acc and dir SHALL freeze; period_tick SHALL be 0; on re-enable, operation SHALL resume from the frozen state.
REQ-021 mode change: a registered copy of mode SHALL be compared each clock. On mismatch, acc, dir and pre_cnt SHALL clear to 0 in the next cycle, with no tick and no period_tick in that cycle.
REQ-022 scale and step changes SHALL take effect at the next evaluation without clearing state. If pre_cnt >= a new scale-1, it SHALL tick and wrap at the next clock.

Reset
REQ-023 While rst=1: pre_cnt, acc, dir, period_tick and the registered mode SHALL be 0, so duty_out=0. The registered mode SHALL load mode on the first clock after release.
REQ-024 Reset assertion mid-period SHALL take effect immediately without waiting for sysclk; the first tick after release SHALL occur scale clocks later.

Verification (WIDTH=6, PRESC_W=6)
REQ-025 Triangle: mode=00, step=2, scale=1.
- duty_out SHALL run 0,2,...,62,63,61,...,1,0 on successive clocks.
- period_tick SHALL pulse once per 64 ticks, on the clock after duty_out returns to 0.
REQ-026 Sawtooth-up: mode=01, step=4, scale=3.
- duty_out SHALL step 0,4,...,60,0, changing every 3 clocks.
- period_tick SHALL pulse every 48 clocks.
REQ-027 Square and sawtooth-down: mode=10, step=4, scale=1.
- duty_out SHALL be 0 for 8 clocks, then 63 for 8 clocks.
- Switching to mode=11 SHALL give duty_out 63 for one cycle (the clear cycle), then 59, 55, ...
REQ-028 Freeze/resume: in triangle at duty_out=20 rising, drop enable for 10 clocks.
- duty_out SHALL be 0 and period_tick 0 throughout.
- On re-enable, duty_out SHALL be 20, then 22 at the next tick.
REQ-029 Edge cases:
- step=0 for 100 clocks: duty_out constant, no period_tick.
- scale=0: behaves identically to scale=1.
- Triangle with step=63: duty_out 0,63,0,63 with a period_tick each return to 0.
REQ-030 Async reset: assert rst between clock edges at duty_out=40.
- duty_out SHALL be 0 before the next sysclk edge.
- After release with scale=5, the first nonzero duty_out SHALL appear on the 5th clock.

Source files
------------

// File: rtl/wave_generator_if.sv
// Control and level bundle between a wave_generator and its host/PWM consumer.
// No handshake: controls are sampled every sysclk, outputs are valid every cycle.
interface wave_generator_if #(
    parameter int WIDTH   = 6,
    parameter int PRESC_W = 6
);
    logic               enable;
    logic [1:0]         mode;
    logic [PRESC_W-1:0] scale;
    logic [WIDTH-1:0]   step;
    logic [WIDTH-1:0]   duty_out;
    logic               period_tick;

    modport master (
        output enable, mode, scale, step,
        input  duty_out, period_tick
    );

    modport slave (
        input  enable, mode, scale, step,
        output duty_out, period_tick
    );
endinterface

// File: rtl/wave_generator.sv
// Triangle / sawtooth / square level generator feeding a PWM duty input; level is combinational from state, period_tick registered.
// No backpressure: free-running while enable=1, all state frozen while enable=0.
module wave_generator #(
    parameter int WIDTH   = 6,
    parameter int PRESC_W = 6
) (
    input  logic             sysclk,
    input  logic             rst,
    wave_generator_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_TRI    = 2'b00,
        MODE_SAW_UP = 2'b01,
        MODE_SQUARE = 2'b10,
        MODE_SAW_DN = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [PRESC_W-1:0] pre_cnt;
    logic [PRESC_W-1:0] pre_cnt_nxt;
    logic [PRESC_W-1:0] scale_m1;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]     sum_up;
    logic               dir;
    logic               dir_nxt;
    logic               ptick_q;
    logic               ptick_nxt;
    mode_e              mode_q;
    logic               mode_chg;
    logic               tick;
    logic [WIDTH-1:0]   duty;

    // scale of 0 behaves as 1, so the terminal count is clamped at 0
    assign scale_m1 = (bus.scale == '0) ? '0 : bus.scale - PRESC_W'(1);
    assign mode_chg = (mode_e'(bus.mode) != mode_q);
    // >= rather than == so a scale reduced below the current count wraps at once
    assign tick     = bus.enable && !mode_chg && (pre_cnt >= scale_m1);
    assign sum_up   = {1'b0, acc} + {1'b0, bus.step};

    always_comb begin
        pre_cnt_nxt = pre_cnt;
        acc_nxt     = acc;
        dir_nxt     = dir;
        ptick_nxt   = 1'b0;
        if (mode_chg) begin
            pre_cnt_nxt = '0;
            acc_nxt     = '0;
            dir_nxt     = 1'b0;
        end else if (bus.enable) begin
            pre_cnt_nxt = tick ? '0 : pre_cnt + PRESC_W'(1);
            if (tick) begin
                if (mode_q == MODE_TRI) begin
                    if (!dir) begin
                        if (sum_up >= {1'b0, MAX}) begin
                            acc_nxt = MAX;
                            dir_nxt = 1'b1;
                        end else begin
                            acc_nxt = sum_up[WIDTH-1:0];
                        end
                    end else if (acc <= bus.step) begin
                        acc_nxt   = '0;
                        dir_nxt   = 1'b0;
                        ptick_nxt = 1'b1;
                    end else begin
                        acc_nxt = acc - bus.step;
                    end
                end else begin
                    acc_nxt   = sum_up[WIDTH-1:0];
                    ptick_nxt = sum_up[WIDTH];
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            acc     <= '0;
            dir     <= 1'b0;
            ptick_q <= 1'b0;
            mode_q  <= MODE_TRI;
        end else begin
            pre_cnt <= pre_cnt_nxt;
            acc     <= acc_nxt;
            dir     <= dir_nxt;
            ptick_q <= ptick_nxt;
            mode_q  <= mode_e'(bus.mode);
        end
    end

    always_comb begin
        duty = '0;
        if (bus.enable) begin
            case (mode_q)
                MODE_TRI, MODE_SAW_UP: duty = acc;
                MODE_SQUARE:           duty = acc[WIDTH-1] ? MAX : '0;
                default:               duty = MAX - acc;
            endcase
        end
    end

    assign bus.duty_out    = duty;
    // gated so a pulse registered just before a freeze never leaks out
    assign bus.period_tick = ptick_q & bus.enable;

endmodule

// File: tb/tb_wave_generator.sv
// Randomized and directed bench for wave_generator against an integer reference model.
module tb_wave_generator;
    localparam int W   = 6;
    localparam int P   = 6;
    localparam int MAX = 63;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    wave_generator_if #(.WIDTH(W), .PRESC_W(P)) wif();

    wave_generator #(.WIDTH(W), .PRESC_W(P)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (wif)
    );

    always #5 sysclk = ~sysclk;

    // reference model state: prescaler count, level, direction, registered mode, pending period pulse
    int m_pre  = 0;
    int m_acc  = 0;
    int m_dir  = 0;
    int m_mode = 0;
    int m_pt   = 0;

    always @(posedge sysclk or posedge rst) begin
        int sc;
        int st;
        int nxt;
        if (rst) begin
            m_pre = 0; m_acc = 0; m_dir = 0; m_mode = 0; m_pt = 0;
        end else begin
            sc = (wif.scale == 0) ? 1 : int'(wif.scale);
            st = int'(wif.step);
            m_pt = 0;
            if (int'(wif.mode) != m_mode) begin
                m_mode = int'(wif.mode);
                m_pre = 0; m_acc = 0; m_dir = 0;
            end else if (wif.enable) begin
                if (m_pre >= sc - 1) begin
                    m_pre = 0;
                    if (m_mode == 0) begin
                        if (m_dir == 0) begin
                            if (m_acc + st >= MAX) begin m_acc = MAX; m_dir = 1; end
                            else m_acc = m_acc + st;
                        end else if (m_acc <= st) begin
                            m_acc = 0; m_dir = 0; m_pt = 1;
                        end else begin
                            m_acc = m_acc - st;
                        end
                    end else begin
                        nxt   = m_acc + st;
                        m_pt  = (nxt > MAX) ? 1 : 0;
                        m_acc = nxt % (MAX + 1);
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
        end
    end

    function automatic int exp_duty();
        if (!wif.enable) return 0;
        case (m_mode)
            0, 1:    return m_acc;
            2:       return (m_acc >= 32) ? MAX : 0;
            default: return MAX - m_acc;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge sysclk) begin
        check("model_duty", 32'(wif.duty_out), exp_duty());
        check("model_ptick", 32'(wif.period_tick), (m_pt != 0 && wif.enable) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    initial begin
        int k;
        int n;
        int r;
        logic [W-1:0] d0;

        wif.enable = 1'b1; wif.mode = 2'd0; wif.scale = 6'd1; wif.step = 6'd2;
        rst = 1'b1;
        cyc(2);
        check("reset_duty", 32'(wif.duty_out), 0);
        check("reset_ptick", 32'(wif.period_tick), 0);
        rst = 1'b0;

        // triangle, step 2, scale 1
        cyc(1);  check("tri_first", 32'(wif.duty_out), 2);
        cyc(30); check("tri_62", 32'(wif.duty_out), 62);
        cyc(1);  check("tri_peak", 32'(wif.duty_out), 63);
        cyc(1);  check("tri_61", 32'(wif.duty_out), 61);
        cyc(30); check("tri_1", 32'(wif.duty_out), 1);
                 check("tri_no_ptick", 32'(wif.period_tick), 0);
        cyc(1);  check("tri_zero", 32'(wif.duty_out), 0);
                 check("tri_ptick", 32'(wif.period_tick), 1);
        cyc(1);  check("tri_restart", 32'(wif.duty_out), 2);
                 check("tri_ptick_end", 32'(wif.period_tick), 0);

        // freeze at 20 while rising
        cyc(9);  check("frz_pre", 32'(wif.duty_out), 20);
        wif.enable = 1'b0; #1;
        check("frz_gate", 32'(wif.duty_out), 0);
        cyc(10);
        wif.enable = 1'b1; #1;
        check("frz_resume", 32'(wif.duty_out), 20);
        cyc(1);  check("frz_next", 32'(wif.duty_out), 22);

        // sawtooth-up, step 4, scale 3
        wif.mode = 2'd1; wif.step = 6'd4; wif.scale = 6'd3;
        cyc(1);  check("saw_clear", 32'(wif.duty_out), 0);
        cyc(2);  check("saw_hold", 32'(wif.duty_out), 0);
        cyc(1);  check("saw_first", 32'(wif.duty_out), 4);
        k = 0;
        while (!wif.period_tick && k < 100) begin cyc(1); k++; end
        check("saw_ptick_seen", (k < 100) ? 1 : 0, 1);
        n = 0;
        do begin cyc(1); n++; end while (!wif.period_tick && n < 100);
        check("saw_period", n, 48);

        // square, step 4, scale 1, then sawtooth-down
        wif.mode = 2'd2; wif.scale = 6'd1;
        cyc(1);  check("sq_clear", 32'(wif.duty_out), 0);
        cyc(7);  check("sq_low_end", 32'(wif.duty_out), 0);
        cyc(1);  check("sq_high", 32'(wif.duty_out), 63);
        cyc(7);  check("sq_high_end", 32'(wif.duty_out), 63);
        cyc(1);  check("sq_wrap", 32'(wif.duty_out), 0);
                 check("sq_ptick", 32'(wif.period_tick), 1);
        wif.mode = 2'd3;
        cyc(1);  check("dn_clear", 32'(wif.duty_out), 63);
                 check("dn_clear_ptick", 32'(wif.period_tick), 0);
        cyc(1);  check("dn_59", 32'(wif.duty_out), 59);
        cyc(1);  check("dn_55", 32'(wif.duty_out), 55);

        // step 0 holds the level for 100 clocks
        wif.step = 6'd0;
        d0 = wif.duty_out; k = 0; n = 0;
        repeat (100) begin
            cyc(1);
            if (wif.duty_out != d0) k++;
            if (wif.period_tick) n++;
        end
        check("step0_changes", k, 0);
        check("step0_pticks", n, 0);

        // scale 0 runs at scale 1 rate
        wif.mode = 2'd1; wif.step = 6'd1; wif.scale = 6'd0;
        cyc(1);  check("sc0_clear", 32'(wif.duty_out), 0);
        cyc(1);  check("sc0_1", 32'(wif.duty_out), 1);
        cyc(1);  check("sc0_2", 32'(wif.duty_out), 2);

        // triangle with maximal step
        wif.mode = 2'd0; wif.step = 6'd63; wif.scale = 6'd1;
        cyc(1);  check("t63_clear", 32'(wif.duty_out), 0);
        cyc(1);  check("t63_top", 32'(wif.duty_out), 63);
        cyc(1);  check("t63_bot", 32'(wif.duty_out), 0);
                 check("t63_ptick", 32'(wif.period_tick), 1);
        cyc(1);  check("t63_top2", 32'(wif.duty_out), 63);

        // asynchronous reset mid-cycle at level 40
        wif.mode = 2'd1; cyc(1);
        wif.mode = 2'd0; wif.step = 6'd4; cyc(1);
        cyc(10); check("ar_pre", 32'(wif.duty_out), 40);
        #1 rst = 1'b1;
        #1 check("ar_immediate", 32'(wif.duty_out), 0);
        cyc(2);
        wif.scale = 6'd5; rst = 1'b0;
        k = 0;
        do begin cyc(1); k++; end while (wif.duty_out == 0 && k < 20);
        check("ar_first_tick", k, 5);
        check("ar_first_level", 32'(wif.duty_out), 4);

        // randomized phase; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 15 && wif.enable) wif.mode = 2'($urandom_range(0, 3));
            else if (r < 50) wif.step = 6'($urandom_range(0, 63));
            else if (r < 75) wif.scale = 6'($urandom_range(0, 6));
            else if (r < 100) wif.enable = ~wif.enable;
            else if (r < 103) begin #1 rst = 1'b1; cyc(1); rst = 1'b0; end
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
